// File: rtl/rob_commit_unit_if.sv
// rtl/rob_commit_unit_if.sv - issue, writeback, lookup and commit signals of the reorder buffer
interface rob_commit_unit_if #(
    parameter int IDX_W  = 4,
    parameter int DATA_W = 32
);
    logic              rob_full;
    logic [IDX_W-1:0]  rob_tail_idx;
    logic              de_in_en;
    logic [1:0]        de_type_in;
    logic [4:0]        de_rd_in;
    logic              de_pred_jump_in;
    logic [DATA_W-1:0] de_alt_pc_in;
    logic [IDX_W-1:0]  qj_idx_in;
    logic [IDX_W-1:0]  qk_idx_in;
    logic              qj_ready_out;
    logic              qk_ready_out;
    logic [DATA_W-1:0] qj_val_out;
    logic [DATA_W-1:0] qk_val_out;
    logic              rs_in_en;
    logic [IDX_W-1:0]  rs_rob_idx_in;
    logic [DATA_W-1:0] rs_val_in;
    logic              rs_jump_in;
    logic              lsb_in_en;
    logic [IDX_W-1:0]  lsb_rob_idx_in;
    logic [DATA_W-1:0] lsb_val_in;
    logic              commit_en;
    logic [4:0]        commit_rd;
    logic [DATA_W-1:0] commit_val;
    logic [IDX_W-1:0]  commit_rob_idx;
    logic              commit_store_en;
    logic              roll_back;
    logic [DATA_W-1:0] roll_back_pc;

    modport master (
        input  rob_full, rob_tail_idx, qj_ready_out, qk_ready_out, qj_val_out, qk_val_out,
               commit_en, commit_rd, commit_val, commit_rob_idx, commit_store_en,
               roll_back, roll_back_pc,
        output de_in_en, de_type_in, de_rd_in, de_pred_jump_in, de_alt_pc_in,
               qj_idx_in, qk_idx_in, rs_in_en, rs_rob_idx_in, rs_val_in, rs_jump_in,
               lsb_in_en, lsb_rob_idx_in, lsb_val_in
    );

    modport slave (
        output rob_full, rob_tail_idx, qj_ready_out, qk_ready_out, qj_val_out, qk_val_out,
               commit_en, commit_rd, commit_val, commit_rob_idx, commit_store_en,
               roll_back, roll_back_pc,
        input  de_in_en, de_type_in, de_rd_in, de_pred_jump_in, de_alt_pc_in,
               qj_idx_in, qk_idx_in, rs_in_en, rs_rob_idx_in, rs_val_in, rs_jump_in,
               lsb_in_en, lsb_rob_idx_in, lsb_val_in
    );
endinterface

// File: rtl/rob_commit_unit.sv
// rtl/rob_commit_unit.sv - reorder buffer with in-order commit and branch rollback
module rob_commit_unit #(
    parameter int ROB_SIZE = 16,
    parameter int IDX_W    = 4,
    parameter int DATA_W   = 32
) (
    input  logic             clk,
    input  logic             rst_in_n,
    input  logic             rdy_in,
    rob_commit_unit_if.slave bus
);
    localparam int            CW       = IDX_W + 1;
    localparam logic [CW-1:0] FULL_LVL = CW'(ROB_SIZE - 1);

    logic              busy     [ROB_SIZE];
    logic              ready    [ROB_SIZE];
    logic [1:0]        e_type   [ROB_SIZE];
    logic [4:0]        e_rd     [ROB_SIZE];
    logic [DATA_W-1:0] e_val    [ROB_SIZE];
    logic              e_pred   [ROB_SIZE];
    logic [DATA_W-1:0] e_alt_pc [ROB_SIZE];
    logic              e_jump   [ROB_SIZE];

    logic [IDX_W-1:0] head;
    logic [IDX_W-1:0] tail;
    logic [CW-1:0]    count;

    logic live;
    logic do_issue;
    logic do_commit;
    logic rs_wr;
    logic lsb_wr;

    // Qualify every state-changing event: nothing moves while paused or during the flush cycle
    always_comb begin
        live      = rdy_in && !bus.roll_back;
        do_issue  = live && bus.de_in_en;
        do_commit = live && busy[head] && ready[head];
        rs_wr     = live && bus.rs_in_en && busy[bus.rs_rob_idx_in];
        lsb_wr    = live && bus.lsb_in_en && busy[bus.lsb_rob_idx_in];
    end

    assign bus.rob_full     = (count >= FULL_LVL);
    assign bus.rob_tail_idx = tail;

    // Operand lookup with same-cycle writeback bypass; the ALU result wins if both match
    always_comb begin
        bus.qj_ready_out = ready[bus.qj_idx_in];
        bus.qj_val_out   = e_val[bus.qj_idx_in];
        bus.qk_ready_out = ready[bus.qk_idx_in];
        bus.qk_val_out   = e_val[bus.qk_idx_in];
        if (bus.lsb_in_en && bus.lsb_rob_idx_in == bus.qj_idx_in) begin
            bus.qj_ready_out = 1'b1;
            bus.qj_val_out   = bus.lsb_val_in;
        end
        if (bus.rs_in_en && bus.rs_rob_idx_in == bus.qj_idx_in) begin
            bus.qj_ready_out = 1'b1;
            bus.qj_val_out   = bus.rs_val_in;
        end
        if (bus.lsb_in_en && bus.lsb_rob_idx_in == bus.qk_idx_in) begin
            bus.qk_ready_out = 1'b1;
            bus.qk_val_out   = bus.lsb_val_in;
        end
        if (bus.rs_in_en && bus.rs_rob_idx_in == bus.qk_idx_in) begin
            bus.qk_ready_out = 1'b1;
            bus.qk_val_out   = bus.rs_val_in;
        end
    end

    // Entry payload; only fields of live entries are ever consumed, so no reset is needed
    always_ff @(posedge clk) begin
        if (do_issue) begin
            e_type[tail]   <= bus.de_type_in;
            e_rd[tail]     <= bus.de_rd_in;
            e_pred[tail]   <= bus.de_pred_jump_in;
            e_alt_pc[tail] <= bus.de_alt_pc_in;
        end
        if (rs_wr) begin
            e_val[bus.rs_rob_idx_in]  <= bus.rs_val_in;
            e_jump[bus.rs_rob_idx_in] <= bus.rs_jump_in;
        end
        if (lsb_wr) begin
            e_val[bus.lsb_rob_idx_in] <= bus.lsb_val_in;
        end
    end

    // Occupancy, pointers and the registered commit/rollback pulses
    always_ff @(posedge clk or negedge rst_in_n) begin
        if (!rst_in_n) begin
            for (int i = 0; i < ROB_SIZE; i++) begin
                busy[i]  <= 1'b0;
                ready[i] <= 1'b0;
            end
            head                <= '0;
            tail                <= '0;
            count               <= '0;
            bus.commit_en       <= 1'b0;
            bus.commit_rd       <= '0;
            bus.commit_val      <= '0;
            bus.commit_rob_idx  <= '0;
            bus.commit_store_en <= 1'b0;
            bus.roll_back       <= 1'b0;
            bus.roll_back_pc    <= '0;
        end else begin
            bus.commit_en       <= 1'b0;
            bus.commit_store_en <= 1'b0;
            bus.roll_back       <= 1'b0;
            if (rdy_in && bus.roll_back) begin
                for (int i = 0; i < ROB_SIZE; i++) begin
                    busy[i]  <= 1'b0;
                    ready[i] <= 1'b0;
                end
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else if (rdy_in) begin
                if (rs_wr) begin
                    ready[bus.rs_rob_idx_in] <= 1'b1;
                end
                if (lsb_wr) begin
                    ready[bus.lsb_rob_idx_in] <= 1'b1;
                end
                if (do_issue) begin
                    busy[tail]  <= 1'b1;
                    ready[tail] <= 1'b0;
                    tail        <= tail + IDX_W'(1);
                end
                if (do_commit) begin
                    busy[head]  <= 1'b0;
                    ready[head] <= 1'b0;
                    head        <= head + IDX_W'(1);
                    case (e_type[head])
                        2'b00: begin
                            bus.commit_en      <= 1'b1;
                            bus.commit_rd      <= e_rd[head];
                            bus.commit_val     <= e_val[head];
                            bus.commit_rob_idx <= head;
                        end
                        2'b01: begin
                            bus.commit_store_en <= 1'b1;
                            bus.commit_rob_idx  <= head;
                        end
                        2'b10: begin
                            if (e_jump[head] != e_pred[head]) begin
                                bus.roll_back    <= 1'b1;
                                bus.roll_back_pc <= e_alt_pc[head];
                            end
                        end
                        default: begin
                            bus.commit_en      <= 1'b1;
                            bus.commit_rd      <= e_rd[head];
                            bus.commit_val     <= e_val[head];
                            bus.commit_rob_idx <= head;
                            bus.roll_back      <= 1'b1;
                            bus.roll_back_pc   <= e_alt_pc[head];
                        end
                    endcase
                end
                count <= count + CW'(do_issue) - CW'(do_commit);
            end
        end
    end
endmodule

// File: tb/tb_rob_commit_unit.sv
// tb/tb_rob_commit_unit.sv - directed bench with a queue model of the reorder buffer
module tb_rob_commit_unit;
    logic clk = 1'b0;
    logic rst_in_n = 1'b1;
    logic rdy_in = 1'b1;

    rob_commit_unit_if #(.IDX_W(4), .DATA_W(32)) bus ();

    rob_commit_unit #(.ROB_SIZE(16), .IDX_W(4), .DATA_W(32)) dut (
        .clk      (clk),
        .rst_in_n (rst_in_n),
        .rdy_in   (rdy_in),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [1:0]  typ;
        logic [4:0]  rd;
        logic        pred;
        logic [31:0] alt;
        logic [31:0] val;
        logic        jump;
        logic        rdy;
    } ent_t;

    ent_t        q[$];
    int          tail_m;
    logic        exp_en, exp_store, exp_rb;
    logic [4:0]  exp_rd;
    logic [31:0] exp_val, exp_pc;
    int          exp_idx;
    logic [31:0] log_val[$];
    int          log_idx[$];
    int          n_store;
    int          ser[16];
    int          n_checks = 0;
    int          n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: what one clock edge must do, given the inputs currently driven
    task automatic model_edge();
        ent_t e;
        logic rb_next;
        exp_en    = 1'b0;
        exp_store = 1'b0;
        rb_next   = 1'b0;
        if (!rdy_in) begin
            exp_rb = 1'b0;
        end else if (exp_rb) begin
            q.delete();
            tail_m = 0;
            exp_rb = 1'b0;
        end else begin
            if (q.size() > 0 && q[0].rdy) begin
                e = q.pop_front();
                if (e.typ == 2'b00 || e.typ == 2'b11) begin
                    exp_en = 1'b1; exp_rd = e.rd; exp_val = e.val; exp_idx = e.idx;
                end
                if (e.typ == 2'b01) begin
                    exp_store = 1'b1; exp_idx = e.idx;
                end
                if (e.typ == 2'b11 || (e.typ == 2'b10 && e.jump != e.pred)) begin
                    rb_next = 1'b1; exp_pc = e.alt;
                end
            end
            foreach (q[i]) begin
                if (bus.rs_in_en && q[i].idx == int'(bus.rs_rob_idx_in)) begin
                    q[i].val = bus.rs_val_in; q[i].jump = bus.rs_jump_in; q[i].rdy = 1'b1;
                end
                if (bus.lsb_in_en && q[i].idx == int'(bus.lsb_rob_idx_in)) begin
                    q[i].val = bus.lsb_val_in; q[i].rdy = 1'b1;
                end
            end
            if (bus.de_in_en) begin
                e = '{idx: tail_m, typ: bus.de_type_in, rd: bus.de_rd_in, pred: bus.de_pred_jump_in,
                      alt: bus.de_alt_pc_in, val: 32'h0, jump: 1'b0, rdy: 1'b0};
                q.push_back(e);
                tail_m = (tail_m + 1) % 16;
            end
            exp_rb = rb_next;
        end
    endtask

    task automatic idle_in();
        bus.de_in_en = 1'b0; bus.rs_in_en = 1'b0; bus.lsb_in_en = 1'b0;
    endtask

    task automatic iss(input logic [1:0] t, input logic [4:0] rd, input logic p, input logic [31:0] alt);
        bus.de_in_en = 1'b1; bus.de_type_in = t; bus.de_rd_in = rd;
        bus.de_pred_jump_in = p; bus.de_alt_pc_in = alt;
    endtask

    task automatic rs(input int idx, input logic [31:0] v, input logic j);
        bus.rs_in_en = 1'b1; bus.rs_rob_idx_in = 4'(idx); bus.rs_val_in = v; bus.rs_jump_in = j;
    endtask

    task automatic lsb(input int idx, input logic [31:0] v);
        bus.lsb_in_en = 1'b1; bus.lsb_rob_idx_in = 4'(idx); bus.lsb_val_in = v;
    endtask

    // One clock: advance the model, take the edge, compare every output against the model
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        chk("commit_en", bus.commit_en, exp_en);
        chk("commit_store_en", bus.commit_store_en, exp_store);
        chk("roll_back", bus.roll_back, exp_rb);
        chk("rob_full", bus.rob_full, q.size() >= 15);
        chk("rob_tail_idx", bus.rob_tail_idx, tail_m);
        if (exp_en) begin
            chk("commit_rd", bus.commit_rd, exp_rd);
            chk("commit_val", bus.commit_val, exp_val);
        end
        if (exp_en || exp_store) chk("commit_rob_idx", bus.commit_rob_idx, exp_idx);
        if (exp_rb) chk("roll_back_pc", bus.roll_back_pc, exp_pc);
        if (bus.commit_en) begin
            log_val.push_back(bus.commit_val);
            log_idx.push_back(int'(bus.commit_rob_idx));
        end
        if (bus.commit_store_en) n_store++;
        idle_in();
    endtask

    function automatic int first_unready();
        foreach (q[i]) if (!q[i].rdy) return i;
        return -1;
    endfunction

    // Write back the oldest pending entry each cycle until the buffer empties
    task automatic drain();
        int u;
        for (int k = 0; k < 100 && q.size() > 0; k++) begin
            u = first_unready();
            if (u >= 0) rs(q[u].idx, 32'h7000 + q[u].idx, q[u].pred);
            step();
        end
        chk("drain_tail_vs_model", bus.rob_tail_idx, tail_m);
    endtask

    task automatic do_reset();
        rst_in_n = 1'b0;
        #1;
        chk("rst_commit_en", bus.commit_en, 0);
        chk("rst_commit_rd", bus.commit_rd, 0);
        chk("rst_commit_val", bus.commit_val, 0);
        chk("rst_commit_idx", bus.commit_rob_idx, 0);
        chk("rst_store_en", bus.commit_store_en, 0);
        chk("rst_roll_back", bus.roll_back, 0);
        chk("rst_roll_back_pc", bus.roll_back_pc, 0);
        chk("rst_rob_full", bus.rob_full, 0);
        chk("rst_tail", bus.rob_tail_idx, 0);
        q.delete(); tail_m = 0;
        exp_en = 0; exp_store = 0; exp_rb = 0;
        @(negedge clk);
        rst_in_n = 1'b1;
    endtask

    initial begin
        int issued, u;
        idle_in();
        bus.qj_idx_in = '0; bus.qk_idx_in = '0;
        bus.de_type_in = '0; bus.de_rd_in = '0; bus.de_pred_jump_in = 1'b0; bus.de_alt_pc_in = '0;
        bus.rs_rob_idx_in = '0; bus.rs_val_in = '0; bus.rs_jump_in = 1'b0;
        bus.lsb_rob_idx_in = '0; bus.lsb_val_in = '0;
        #1;
        do_reset();

        // In-order commit of out-of-order results
        log_val.delete(); log_idx.delete();
        for (int i = 1; i <= 3; i++) begin iss(2'b00, 5'(i), 1'b0, 0); step(); end
        rs(2, 32'h30, 1'b0); step();
        rs(0, 32'h10, 1'b0); step();
        rs(1, 32'h20, 1'b0); step();
        step(); step(); step();
        chk("t1_ncommit", log_val.size(), 3);
        chk("t1_val0", log_val[0], 32'h10);
        chk("t1_val1", log_val[1], 32'h20);
        chk("t1_val2", log_val[2], 32'h30);
        chk("t1_idx2", log_idx[2], 2);

        // Fill to 15, free one, then keep streaming across the index wrap
        log_val.delete();
        for (int k = 0; k < 15; k++) begin
            ser[tail_m] = k; iss(2'b00, 5'(k + 1), 1'b0, 0); step();
        end
        chk("t2_full", bus.rob_full, 1);
        rs(q[0].idx, 32'h5000 + ser[q[0].idx], 1'b0); step();
        step();
        chk("t2_not_full", bus.rob_full, 0);
        issued = 15;
        for (int k = 0; k < 200 && (issued < 20 || q.size() > 0); k++) begin
            if (issued < 20 && q.size() <= 14) begin
                ser[tail_m] = issued; iss(2'b00, 5'(issued + 1), 1'b0, 0); issued++;
            end
            u = first_unready();
            if (u >= 0) rs(q[u].idx, 32'h5000 + ser[q[u].idx], 1'b0);
            step();
        end
        chk("t2_ncommit", log_val.size(), 20);
        for (int i = 0; i < 20; i += 5) chk("t2_order", log_val[i], 32'h5000 + i);
        chk("t2_wrap_tail", bus.rob_tail_idx, 7);

        // Mispredicted branch flushes younger ready entries
        log_val.delete();
        iss(2'b10, 5'd0, 1'b0, 32'h1000); step();
        iss(2'b00, 5'd5, 1'b0, 0); step();
        iss(2'b00, 5'd6, 1'b0, 0); step();
        rs(8, 32'h55, 1'b0); lsb(9, 32'h66); step();
        rs(7, 32'h0, 1'b1); step();
        step();
        chk("t3_roll_back", bus.roll_back, 1);
        chk("t3_roll_back_pc", bus.roll_back_pc, 32'h1000);
        iss(2'b00, 5'd9, 1'b0, 0); step();
        chk("t3_rb_one_cycle", bus.roll_back, 0);
        chk("t3_tail_zero", bus.rob_tail_idx, 0);
        step(); step();
        chk("t3_no_commit", log_val.size(), 0);

        // Lookup bypass
        for (int i = 0; i < 6; i++) begin iss(2'b00, 5'(i + 1), 1'b0, 0); step(); end
        rs(5, 32'hABCD, 1'b0); bus.qj_idx_in = 4'd5; bus.qk_idx_in = 4'd4;
        #1;
        chk("t4_qj_ready_bypass", bus.qj_ready_out, 1);
        chk("t4_qj_val_bypass", bus.qj_val_out, 32'hABCD);
        chk("t4_qk_not_ready", bus.qk_ready_out, 0);
        step();
        chk("t4_qj_ready_stored", bus.qj_ready_out, 1);
        chk("t4_qj_val_stored", bus.qj_val_out, 32'hABCD);
        drain();

        // Store commit and dual writeback
        do_reset();
        iss(2'b01, 5'd0, 1'b0, 0); step();
        iss(2'b00, 5'd7, 1'b0, 0); step();
        iss(2'b00, 5'd8, 1'b0, 0); step();
        rs(1, 32'h77, 1'b0); lsb(2, 32'h88); step();
        bus.qj_idx_in = 4'd1; bus.qk_idx_in = 4'd2;
        #1;
        chk("t5_qj_ready", bus.qj_ready_out, 1);
        chk("t5_qk_ready", bus.qk_ready_out, 1);
        chk("t5_qk_val", bus.qk_val_out, 32'h88);
        log_val.delete(); n_store = 0;
        lsb(0, 32'hDEAD); step();
        step(); step(); step(); step();
        chk("t5_nstore", n_store, 1);
        chk("t5_ncommit", log_val.size(), 2);
        chk("t5_first_val", log_val[0], 32'h77);

        // Pause holds a ready head
        log_val.delete();
        iss(2'b00, 5'd9, 1'b0, 0); step();
        rs(3, 32'h99, 1'b0); step();
        rdy_in = 1'b0;
        step(); step(); step();
        chk("t6_paused", log_val.size(), 0);
        rdy_in = 1'b1;
        step(); step();
        chk("t6_one_commit", log_val.size(), 1);

        // Asynchronous reset while a commit pulse is high
        iss(2'b00, 5'd10, 1'b0, 0); step();
        rs(4, 32'hAA, 1'b0); step();
        step();
        chk("t7_pulse_before_reset", bus.commit_en, 1);
        do_reset();
        step(); step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/rob_commit_unit.md
Name: rob_commit_unit

Overview:
Reorder buffer that sits directly downstream of the reservation station and load/store buffer. It allocates one entry per decoded instruction and captures CDB results (ALU from rs, loads from lsb). It commits strictly in program order to the register file and store path. It raises roll_back on a mispredicted branch at commit; roll_back flushes the reservation station, the lsb and this block.

Parameters:
ROB_SIZE, 16, number of entries (power of two)
IDX_W, 4, log2(ROB_SIZE), width of a rob index
DATA_W, 32, data/address width

Ports:
clk  in  1  system clock
rst_in_n  in  1  asynchronous active-low reset
rdy_in  in  1  pause when low; all state holds
rob_full  out  1  decoder must not issue while high
rob_tail_idx  out  IDX_W  index the next issued instruction receives
de_in_en  in  1  issue valid
de_type_in  in  2  00 reg-write, 01 store, 10 branch, 11 jalr (reg-write plus redirect)
de_rd_in  in  5  destination register
de_pred_jump_in  in  1  predicted taken (branch only)
de_alt_pc_in  in  DATA_W  pc to redirect to if the prediction is wrong
qj_idx_in, qk_idx_in  in  IDX_W  operand lookup indices from the decoder
qj_ready_out, qk_ready_out  out  1  looked-up entry has its value
qj_val_out, qk_val_out  out  DATA_W  looked-up value
rs_in_en  in  1  ALU result valid
rs_rob_idx_in  in  IDX_W  ALU result index
rs_val_in  in  DATA_W  ALU result value
rs_jump_in  in  1  branch outcome (valid for branch entries)
lsb_in_en  in  1  load/store done
lsb_rob_idx_in  in  IDX_W  lsb result index
lsb_val_in  in  DATA_W  lsb result value
commit_en  out  1  one-cycle pulse: reg-write commit
commit_rd  out  5  committed rd
commit_val  out  DATA_W  committed value
commit_rob_idx  out  IDX_W  committed index; regfile clears a rename tag that matches it
commit_store_en  out  1  one-cycle pulse: head store may write memory
roll_back  out  1  one-cycle flush pulse
roll_back_pc  out  DATA_W  redirect target

Behaviour:
- Storage: circular buffer with head, tail and count (IDX_W+1 bits). Each entry holds busy, ready, type, rd, val, pred_jump, alt_pc and jump.
- Reset (async, rst_in_n low): head=tail=count=0; all busy and ready bits 0.
  - All registered outputs read 0: commit_en, commit_rd, commit_val, commit_rob_idx, commit_store_en, roll_back, roll_back_pc.
- rob_full: combinational, equals (count >= ROB_SIZE-1). rob_tail_idx equals tail.
- Issue: on an edge with de_in_en, entry[tail] is written with busy=1 and ready=0, except type 01 (store), which gets ready=0 until lsb reports. tail increments modulo ROB_SIZE.
- Writeback:
  - On an edge with rs_in_en, entry[rs_rob_idx_in] gets val and jump, and ready=1.
  - lsb_in_en does the same with lsb_val_in.
  - Both may fire on the same edge to different indices. Both firing to the same index is illegal and its result is unspecified.
  - Writeback to a non-busy entry is ignored.
- Lookup: combinational. qX_ready_out = entry ready OR a same-cycle rs/lsb writeback to that index (bypass). qX_val_out takes the bypassed value first.
- Commit: at most one per edge. It occurs when head is busy and ready and roll_back is 0; the entry is then freed and head increments. Outputs are registered, and each pulse lasts exactly one cycle.
  - reg-write: commit_en=1 with rd, val and idx. rd=0 still pulses; the regfile ignores it.
  - store: commit_store_en=1 with commit_rob_idx.
  - branch: no write. If jump != pred_jump, roll_back=1 and roll_back_pc=alt_pc.
  - jalr: commit_en=1 and roll_back=1 on the same edge, with roll_back_pc=alt_pc.
- Rollback cycle (roll_back high):
  - On the next edge all busy and ready bits clear and head=tail=count=0.
  - de_in_en, rs_in_en and lsb_in_en are ignored on that edge.
  - No commit is performed on that edge.
- count: issue and commit on the same edge leave count unchanged. Issue into a full buffer is illegal and is not guarded.
- Wrap-around: head and tail wrap modulo ROB_SIZE. Indices are raw positions, so tags stay unique while an entry is live.
- rdy_in low: no state changes; commit_en, commit_store_en and roll_back are driven 0 on that edge.
- Latency:
  - A writeback at edge N to the head entry produces the commit pulse at edge N+1.
  - A writeback at edge N to a non-head entry sets ready at N; that entry commits after all older entries.

Test Plan:
- Reset then issue 3 reg-writes (rd=1,2,3). rs writes idx2=0x30, idx0=0x10, idx1=0x20 on consecutive edges. -> commits in order rd1=0x10, rd2=0x20, rd3=0x30 on consecutive cycles, with commit_rob_idx 0,1,2.
- Issue 15 entries -> rob_full=1 at count=15. One commit -> rob_full=0. Issue 20 total with writebacks -> tail wraps from 15 to 0 and commit order is preserved.
- Branch with pred_jump=0, alt_pc=0x1000, rs_jump_in=1 -> roll_back=1 for one cycle with roll_back_pc=0x1000. Younger ready entries never commit; count=0 afterwards.
- Lookup of idx5 on the same cycle as rs writeback idx5=0xABCD -> qj_ready_out=1 and qj_val_out=0xABCD combinationally.
- Store at head with lsb_in_en -> commit_store_en pulses once and commit_en stays 0. rs and lsb writebacks to indices 1 and 2 on the same edge -> both entries ready.
- Hold rdy_in=0 for 3 cycles with head ready -> no commit pulse. rdy_in returns to 1 -> exactly one commit. Assert rst_in_n low mid-stream -> all outputs 0 immediately.
